// File: rtl/ssemi_multi_clock_divider_pkg.sv
// Package for the multi-channel clock divider: default parameters,
// the per-channel operating mode and the channel-index width helper.
`include "ssemi_defines.vh"

package ssemi_multi_clock_divider_pkg;

    localparam int MCD_NUM_CH_MAX    = `SSEMI_MCD_NUM_CH_MAX;
    localparam int MCD_NUM_CH_DEF    = 4;
    localparam int MCD_DIV_W_DEF     = `SSEMI_MCD_DIV_W_DEF;
    localparam int MCD_RATIO_RST_DEF = `SSEMI_MCD_RATIO_RST;

    // What a channel does on the coming clock edge.
    typedef enum logic [1:0] {
        CH_MODE_IDLE  = 2'd0,   // enable low: parked at zero
        CH_MODE_SYNC  = 2'd1,   // phase align: restart from zero
        CH_MODE_COUNT = 2'd2    // normal counting
    } ch_mode_e;

    // Width of the channel select field; a single channel still gets one bit.
    function automatic int mcd_ch_width(input int num_ch);
        if (num_ch > 1) begin
            return $clog2(num_ch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ssemi_clk_div_channel.sv
// One divider channel: counter, active ratio, shadow ratio and pending flag.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_enable       : channel enable; low parks the counter at zero
//   i_sync         : phase align, restart the period from zero
//   i_wr           : validated ratio write for this channel (already accepted)
//   i_wr_ratio     : ratio carried by the write
//   o_pending      : shadow ratio waiting to become active
//   o_clk_div      : registered divided clock level
//   o_stb          : registered one-cycle strobe, once per divided period
module ssemi_clk_div_channel
    import ssemi_multi_clock_divider_pkg::*;
#(
    parameter int DIV_W     = MCD_DIV_W_DEF,
    parameter int RATIO_RST = MCD_RATIO_RST_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_ratio,
    output logic             o_pending,
    output logic             o_clk_div,
    output logic             o_stb
);

    localparam logic [DIV_W-1:0] RATIO_INIT = DIV_W'(RATIO_RST);
    localparam logic [DIV_W-1:0] ONE_V      = DIV_W'(1'b1);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] ratio_r;
    logic [DIV_W-1:0] shadow_r;
    logic             pending_r;
    logic             clk_div_r;
    logic             stb_r;

    logic [DIV_W-1:0] cnt_nxt_s;
    logic [DIV_W-1:0] ratio_nxt_s;
    logic [DIV_W-1:0] shadow_nxt_s;
    logic             pending_nxt_s;
    logic             clk_div_nxt_s;
    logic             stb_nxt_s;

    logic             last_s;
    logic [DIV_W:0]   ratio_p1_s;
    logic [DIV_W-1:0] half_s;
    logic             high_s;
    ch_mode_e         mode_s;

    // Period bookkeeping: last count of the period and the high-phase length.
    // ceil(R/2) is (R+1)>>1, taken as the upper bits of the widened sum so
    // odd ratios spend the extra cycle high.
    always_comb begin
        last_s     = (cnt_r == (ratio_r - ONE_V));
        ratio_p1_s = {1'b0, ratio_r} + (DIV_W + 1)'(1'b1);
        half_s     = ratio_p1_s[DIV_W:1];
        high_s     = (cnt_r < half_s);
    end

    // Mode select: a low enable wins over sync, sync wins over counting.
    always_comb begin
        mode_s = CH_MODE_IDLE;
        if (!i_enable) begin
            mode_s = CH_MODE_IDLE;
        end else if (i_sync) begin
            mode_s = CH_MODE_SYNC;
        end else begin
            mode_s = CH_MODE_COUNT;
        end
    end

    // Next-state and next-output logic for the channel.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        ratio_nxt_s   = ratio_r;
        shadow_nxt_s  = shadow_r;
        pending_nxt_s = pending_r;
        clk_div_nxt_s = 1'b0;
        stb_nxt_s     = 1'b0;
        case (mode_s)
            CH_MODE_IDLE: begin
                // Nothing is running, so a waiting ratio can take over at once.
                cnt_nxt_s = {DIV_W{1'b0}};
                if (pending_r) begin
                    ratio_nxt_s   = shadow_r;
                    pending_nxt_s = 1'b0;
                end else if (i_wr) begin
                    shadow_nxt_s  = i_wr_ratio;
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = 1'b0;
                end
            end
            CH_MODE_SYNC: begin
                // A write landing with sync is made active directly.
                cnt_nxt_s = {DIV_W{1'b0}};
                if (i_wr) begin
                    ratio_nxt_s   = i_wr_ratio;
                    shadow_nxt_s  = i_wr_ratio;
                    pending_nxt_s = 1'b0;
                end else if (pending_r) begin
                    ratio_nxt_s   = shadow_r;
                    pending_nxt_s = 1'b0;
                end else begin
                    pending_nxt_s = 1'b0;
                end
            end
            CH_MODE_COUNT: begin
                clk_div_nxt_s = high_s;
                stb_nxt_s     = last_s;
                if (last_s) begin
                    cnt_nxt_s = {DIV_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + ONE_V;
                end
                // Ratio swaps only at the wrap so a period is never cut short.
                if (last_s && pending_r) begin
                    ratio_nxt_s   = shadow_r;
                    pending_nxt_s = 1'b0;
                end else if (i_wr) begin
                    shadow_nxt_s  = i_wr_ratio;
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            default: begin
                cnt_nxt_s     = {DIV_W{1'b0}};
                ratio_nxt_s   = ratio_r;
                shadow_nxt_s  = shadow_r;
                pending_nxt_s = pending_r;
            end
        endcase
    end

    // Channel state and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r     <= {DIV_W{1'b0}};
            ratio_r   <= RATIO_INIT;
            shadow_r  <= RATIO_INIT;
            pending_r <= 1'b0;
            clk_div_r <= 1'b0;
            stb_r     <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            ratio_r   <= ratio_nxt_s;
            shadow_r  <= shadow_nxt_s;
            pending_r <= pending_nxt_s;
            clk_div_r <= clk_div_nxt_s;
            stb_r     <= stb_nxt_s;
        end
    end

    assign o_pending = pending_r;
    assign o_clk_div = clk_div_r;
    assign o_stb     = stb_r;

endmodule

// File: rtl/ssemi_defines.vh
// Shared build-time constants for the ssemi multi-channel clock divider.
//   SSEMI_MCD_NUM_CH_MAX : largest supported channel count
//   SSEMI_MCD_DIV_W_DEF  : default ratio width in bits
//   SSEMI_MCD_RATIO_RST  : ratio every channel takes out of reset
`ifndef SSEMI_DEFINES_VH
`define SSEMI_DEFINES_VH

`define SSEMI_MCD_NUM_CH_MAX 16
`define SSEMI_MCD_DIV_W_DEF  8
`define SSEMI_MCD_RATIO_RST  2

`endif

// File: rtl/ssemi_multi_clock_divider.sv
// Multi-channel programmable clock divider. Holds the ratio-write decode and
// error reporting; each channel is an ssemi_clk_div_channel instance.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_enable       : per-channel enable
//   i_sync         : phase align all channels
//   i_cfg_valid    : ratio write request
//   i_cfg_ch       : target channel of the write
//   i_cfg_ratio    : requested ratio
//   o_cfg_ready    : write accepted when i_cfg_valid && o_cfg_ready
//   o_cfg_err      : one-cycle pulse after an accepted but rejected write
//   o_clk_div      : divided clock level per channel
//   o_stb          : one-cycle strobe per divided period per channel
module ssemi_multi_clock_divider
    import ssemi_multi_clock_divider_pkg::*;
#(
    parameter int  NUM_CH    = MCD_NUM_CH_DEF,
    parameter int  DIV_W     = MCD_DIV_W_DEF,
    parameter int  RATIO_RST = MCD_RATIO_RST_DEF,
    localparam int CH_W      = mcd_ch_width(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_enable,
    input  logic              i_sync,
    input  logic              i_cfg_valid,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [DIV_W-1:0]  i_cfg_ratio,
    output logic              o_cfg_ready,
    output logic              o_cfg_err,
    output logic [NUM_CH-1:0] o_clk_div,
    output logic [NUM_CH-1:0] o_stb
);

    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    // Reject parameter sets the channels cannot represent.
    if ((NUM_CH < 1) || (NUM_CH > MCD_NUM_CH_MAX)) begin : g_bad_num_ch
        $error("ssemi_multi_clock_divider: NUM_CH=%0d outside 1..%0d",
               NUM_CH, MCD_NUM_CH_MAX);
    end
    if ((RATIO_RST < 1) || (RATIO_RST > ((2 ** DIV_W) - 1))) begin : g_bad_ratio_rst
        $error("ssemi_multi_clock_divider: RATIO_RST=%0d outside 1..2^DIV_W-1",
               RATIO_RST);
    end

    logic [NUM_CH-1:0] pending_s;
    logic [NUM_CH-1:0] wr_s;
    logic              ch_in_range_s;
    logic              cfg_ready_s;
    logic              accept_s;
    logic              bad_s;
    logic              good_s;
    logic              cfg_err_r;

    // Write handshake. An index past the last channel still handshakes so the
    // requester never stalls; it is then reported as an error.
    always_comb begin
        ch_in_range_s = ({1'b0, i_cfg_ch} < NUM_CH_V);
        if (ch_in_range_s) begin
            cfg_ready_s = ~pending_s[i_cfg_ch];
        end else begin
            cfg_ready_s = 1'b1;
        end
        accept_s = i_cfg_valid & cfg_ready_s;
        bad_s    = accept_s & (~ch_in_range_s | (i_cfg_ratio == {DIV_W{1'b0}}));
        good_s   = accept_s & ~bad_s;
    end

    // Route an accepted, legal write to its channel.
    always_comb begin
        wr_s = {NUM_CH{1'b0}};
        for (int n = 0; n < NUM_CH; n++) begin
            if ({1'b0, i_cfg_ch} == (CH_W + 1)'(n)) begin
                wr_s[n] = good_s;
            end else begin
                wr_s[n] = 1'b0;
            end
        end
    end

    // Error pulse lands in the cycle after the rejected write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= bad_s;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        ssemi_clk_div_channel #(
            .DIV_W     (DIV_W),
            .RATIO_RST (RATIO_RST)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_enable   (i_enable[n]),
            .i_sync     (i_sync),
            .i_wr       (wr_s[n]),
            .i_wr_ratio (i_cfg_ratio),
            .o_pending  (pending_s[n]),
            .o_clk_div  (o_clk_div[n]),
            .o_stb      (o_stb[n])
        );
    end

    assign o_cfg_ready = cfg_ready_s;
    assign o_cfg_err   = cfg_err_r;

endmodule

// File: doc/ssemi_multi_clock_divider.md
SSEMI_MULTI_CLOCK_DIVIDER -- requirements
Module: ssemi_multi_clock_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, ratio width; legal ratios 1..2^DIV_W-1.
REQ-003 SHALL have parameter RATIO_RST, default 2, active and shadow ratio of every channel after reset.
REQ-004 SHALL have port i_clk, input, 1, clock; all logic rising-edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_enable, input, NUM_CH, per-channel enable.
REQ-007 SHALL have port i_sync, input, 1, synchronous phase-align for all channels.
REQ-008 SHALL have port i_cfg_valid, input, 1, ratio write request.
REQ-009 SHALL have port i_cfg_ch, input, CH_W=max(1,clog2(NUM_CH)), target channel.
REQ-010 SHALL have port i_cfg_ratio, input, DIV_W, requested ratio.
REQ-011 SHALL have port o_cfg_ready, output, 1, write accepted when i_cfg_valid && o_cfg_ready.
REQ-012 SHALL have port o_cfg_err, output, 1, one-cycle pulse for a rejected accepted write.
REQ-013 SHALL have port o_clk_div, output, NUM_CH, divided clock level per channel.
REQ-014 SHALL have port o_stb, output, NUM_CH, one-cycle strobe per divided period.

Function
REQ-015 Each channel SHALL keep counter cnt, active ratio R, shadow ratio S, and a pending flag.
REQ-016 While i_enable[n] is low, cnt[n] SHALL be 0, o_clk_div[n] and o_stb[n] 0 from the next edge, and any pending S SHALL load into R on that edge.
REQ-017 On each edge with i_enable[n] high: cnt <= (cnt==R-1) ? 0 : cnt+1.
REQ-018 Same edge: o_stb[n] <= (cnt==R-1); o_clk_div[n] <= (cnt < ceil(R/2)); registered outputs, no combinational path from inputs.
REQ-019 Odd R: o_clk_div high ceil(R/2) cycles, low floor(R/2). R=1: o_clk_div and o_stb constantly 1 while enabled.
REQ-020 First strobe SHALL be visible after the R-th enabled edge, then every R cycles.
REQ-021 o_cfg_ready SHALL be the inverse of pending[i_cfg_ch] (combinational); an out-of-range channel index gives ready=1.
REQ-022 An accepted write with i_cfg_ratio==0 or i_cfg_ch>=NUM_CH SHALL leave state unchanged and pulse o_cfg_err in the following cycle.
REQ-023 An accepted valid write SHALL set S=i_cfg_ratio and pending=1.
REQ-024 A pending S SHALL load into R on the edge where cnt==R-1 (wrap); pending clears on the same edge; no period is ever truncated.
REQ-025 While i_sync is high, every channel SHALL load cnt=0, load any pending S (including a write accepted in the same cycle) into R, clear pending, and drive outputs 0 on the next edge; counting resumes on the first edge with i_sync low.
REQ-026 i_sync SHALL take priority over wrap and enable-high counting; enable low and i_sync together behave as enable low.

Reset
REQ-027 Asserting i_rst_n low SHALL asynchronously set cnt=0, R=S=RATIO_RST, pending=0, o_clk_div=0, o_stb=0, o_cfg_err=0, regardless of operation in progress.
REQ-028 After deassertion, no output SHALL change before the first edge with i_enable high.

Structure
REQ-029 SSEMI_MCD_NUM_CH_MAX (16), SSEMI_MCD_DIV_W_DEF (8), and SSEMI_MCD_RATIO_RST (2) SHALL live in ssemi_defines.vh.
REQ-030 Per-channel logic SHALL be sub-module ssemi_clk_div_channel, generated NUM_CH times; the top holds config decode and error logic.
REQ-031 Parameter checks SHALL raise $error for NUM_CH outside 1..16 or RATIO_RST outside 1..2^DIV_W-1.

Verification
REQ-032 Reset, enable ch0 with R=4 -> o_stb[0] every 4 cycles, first after the 4th enabled edge; o_clk_div[0] pattern 1100.
REQ-033 Write ch1 ratio 5 mid-period -> current period completes at R=2; next periods 5 cycles, o_clk_div[1] 11100; o_cfg_ready low for ch1 until wrap.
REQ-034 Write ratio 0, then write ch=NUM_CH -> o_cfg_err pulses once each, ratios unchanged, no stall.
REQ-035 Ch0 R=3, ch2 R=6, pulse i_sync -> outputs 0 next cycle; after release, both strobes coincide every 6 cycles.
REQ-036 R=1 on ch3 -> o_stb[3] and o_clk_div[3] constantly 1; drop enable -> both 0 next edge; assert i_rst_n low mid-period -> all outputs 0 immediately, R back to 2.
